ps2_receiver: RTL
=================

Name: ps2_receiver

Overview:
- Receives the PS/2 serial stream from the keyboard and delivers each scan-code byte to the keyboard display stage.
- Synchronises the asynchronous ps2_clk/ps2_data pins into the clk domain and detects ps2_clk falling edges.
- Deframes 11-bit frames: start, 8 data bits LSB-first, odd parity, stop.
- Outputs rx_data plus a one-cycle rx_valid pulse, which drives the display stage's data/receive-flag inputs directly.

Parameters:
- SYNC_STAGES, 3, synchroniser flop depth for ps2_clk and ps2_data; legal range 2..4.
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned (used only with the optional feature).
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- rx_data  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle pulse: rx_data was updated this cycle.
- parity_err  out  1  one-cycle pulse: frame discarded because of bad parity.
- frame_err  out  1  one-cycle pulse: frame discarded because of a bad stop bit or a timeout.
- frame_cnt  out  8  count of good frames, wraps 255 -> 0.

Behaviour:
- Reset: while rst=0, every flop clears. rx_data=0, rx_valid=0, parity_err=0, frame_err=0, frame_cnt=0, state=IDLE, bit counter=0, shift register=0. Synchroniser flops reset to 1 (the idle-high bus level) so no spurious edge is seen on release.
- Synchroniser: ps2_clk and ps2_data each pass through SYNC_STAGES flops with identical depth, so the two stay aligned.
- Edge detect: fall = (delay flop == 1) && (synchronised clk == 0). fall is a one-cycle strobe. Data is sampled from the synchronised ps2_data in the fall cycle.
- Latency: raw ps2_clk falling edge to fall strobe is SYNC_STAGES+1 clk cycles.
- FSM states, one-hot: IDLE=4'b0001, DATA=4'b0010, PARITY=4'b0100, STOP=4'b1000. Transitions happen only on fall; otherwise the state holds.
- IDLE:
  - data==0 -> DATA, bit_cnt=0.
  - data==1 -> stay in IDLE, no error pulse (treated as a glitch).
- DATA: shift the sampled bit in LSB-first (shift <= {d, shift[7:1]}), bit_cnt++. On the fall that captures the 8th bit, go to PARITY.
- PARITY: register par_ok = ^{shift, d} == 1 (odd parity). Go to STOP.
- STOP, on the fall event, then return to IDLE:
  - d==1 and par_ok=1: rx_data <= shift; rx_valid=1 for one cycle; frame_cnt++.
  - d==1 and par_ok=0: parity_err pulse; rx_data unchanged.
  - d==0: frame_err pulse, regardless of parity; rx_data unchanged.
- Output timing: all pulses are registered. They assert in the cycle after the stop-bit fall strobe. rx_data changes in the same cycle as rx_valid and holds until the next good frame.
- Simultaneous events: at most one of rx_valid/parity_err/frame_err is high in any cycle.
- Back-to-back frames need no idle gap beyond the PS/2 protocol itself.
- Reset asserted mid-frame: the partial frame is discarded, no pulse is generated, and the block is in IDLE with cleared outputs on release.
- The block applies no break-code (F0) interpretation; every valid byte is forwarded.

Optional Feature:
- Macro PS2_RX_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on every fall and while in IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 in a non-IDLE state: FSM -> IDLE, counter clears, frame_err pulses next cycle.
- Not defined:
  - No counter is present.
  - A truncated frame waits indefinitely, and the next falls continue it.

Decomposition:
- Package ps2_pkg holds:
  - state encodings IDLE/DATA/PARITY/STOP;
  - PS2_DATA_BITS=8;
  - the break-code constant PS2_BREAK=8'hF0, shared with the display stage.
- Sub-module ps2_sync_edge(clk, rst, ps2_clk, ps2_data -> fall, d_sync), parameterised by SYNC_STAGES. It is reused later by the PS/2 host-transmit path.

Test Plan:
- Frame 0x1C: bits 0,0,0,1,1,1,0,0,0 + parity 0 + stop 1, 30 us bit period -> one rx_valid, rx_data=8'h1C, frame_cnt=1, no error pulses.
- Frames F0 then 1C back-to-back (F0 parity=1) -> two rx_valid pulses, rx_data sequence F0, 1C, frame_cnt=2.
- 0x1C with parity bit 1 -> parity_err single pulse; rx_data keeps its previous value; frame_cnt unchanged.
- 0x1C with stop bit 0 -> frame_err single pulse, no rx_valid; the next good frame 0x32 is accepted normally.
- Send 4 bits and stop toggling:
  - with PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100 -> frame_err ~100 cycles after the last fall, then a full 0x1C is received correctly;
  - without the macro -> no pulse.
- Assert rst low for 3 cycles after bit 5 of a frame, then send 0x1C -> all outputs 0 during reset, no pulse for the partial frame, then rx_data=8'h1C and frame_cnt=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 receive path shared definitions: FSM encodings, frame geometry, break code.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        DATA   = 4'b0010,
        PARITY = 4'b0100,
        STOP   = 4'b1000
    } state_t;

    localparam int          PS2_DATA_BITS = 8;
    localparam logic [7:0]  PS2_BREAK     = 8'hF0;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises ps2_clk/ps2_data into clk and strobes fall on each ps2_clk falling edge.
// Latency: SYNC_STAGES+1 clk cycles from raw falling edge to fall strobe.
// Backpressure: none; fall is a one-cycle strobe with d_sync valid alongside it.
`timescale 1ns/1ps
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic d_sync
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] dat_sr;
    logic                   clk_d;

    // Reset to the idle-high bus level so release never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sr <= '1;
            dat_sr <= '1;
            clk_d  <= 1'b1;
        end else begin
            clk_sr <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            dat_sr <= {dat_sr[SYNC_STAGES-2:0], ps2_data};
            clk_d  <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_d & ~clk_sr[SYNC_STAGES-1];
    assign d_sync = dat_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_receiver.sv
// Deframes PS/2 keyboard frames into rx_data with rx_valid/parity_err/frame_err pulses; optional stall timeout via PS2_RX_TIMEOUT_EN.
// Latency: pulses assert the cycle after the stop-bit fall strobe.
// Backpressure: none; every pulse is one cycle and must be taken when seen.
`timescale 1ns/1ps
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("ps2_receiver: SYNC_STAGES must be 2..4");
    end
    if (TO_W < 31 && (64'(1) << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_to_w
        $error("ps2_receiver: TO_W too narrow for TIMEOUT_CYCLES");
    end

    logic fall;
    logic d_sync;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .d_sync   (d_sync)
    );

    state_t     state_q, state_n;
    logic [2:0] bit_cnt_q, bit_cnt_n;
    logic [7:0] shift_q, shift_n;
    logic       par_ok_q, par_ok_n;
    logic [7:0] rx_data_n, frame_cnt_n;
    logic       rx_valid_n, parity_err_n, frame_err_n;

`ifdef PS2_RX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_n;
    logic            timeout_hit;

    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_cnt_q <= '0;
        else      to_cnt_q <= to_cnt_n;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            shift_q    <= shift_n;
            par_ok_q   <= par_ok_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        bit_cnt_n    = bit_cnt_q;
        shift_n      = shift_q;
        par_ok_n     = par_ok_q;
        rx_data_n    = rx_data;
        frame_cnt_n  = frame_cnt;
        rx_valid_n   = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
        to_cnt_n     = (fall || state_q == IDLE || timeout_hit) ? '0 : to_cnt_q + 1'b1;
`endif

        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    // A high start bit is a line glitch, not a framing error.
                    if (!d_sync) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {d_sync, shift_q[7:1]};
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_n = PARITY;
                end
                PARITY: begin
                    par_ok_n = ^{shift_q, d_sync};
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!d_sync) begin
                        frame_err_n = 1'b1;
                    end else if (!par_ok_q) begin
                        parity_err_n = 1'b1;
                    end else begin
                        rx_data_n   = shift_q;
                        rx_valid_n  = 1'b1;
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        else if (timeout_hit) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
        end
`endif
    end

endmodule
